// File: rtl/mips_pkg.sv
// Shared MIPS memory-op definitions: load/store op codes, LSU FSM states
// and the op/alignment legality check.
package mips_pkg;

  // Low three bits of req_op (the MIPS load/store opcode low bits).
  localparam logic [2:0] OP_B  = 3'b000;
  localparam logic [2:0] OP_H  = 3'b001;
  localparam logic [2:0] OP_W  = 3'b011;
  localparam logic [2:0] OP_BU = 3'b100;
  localparam logic [2:0] OP_HU = 3'b101;

  // Bit of req_op that marks a store.
  localparam int ST_BIT = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LD_RD,
    S_LD_DATA,
    S_ST_WR,
    S_RMW_RD,
    S_RMW_MRG,
    S_RMW_WR,
    S_ERR
  } lsu_state_e;

  // True when the op is unsupported or the address is misaligned for its size.
  function automatic logic op_error(input logic [3:0] op, input logic [1:0] byte_off);
    logic is_store;
    is_store = op[ST_BIT];
    case (op[2:0])
      OP_B:    op_error = 1'b0;
      OP_H:    op_error = byte_off[0];
      OP_W:    op_error = (byte_off != 2'b00);
      OP_BU:   op_error = is_store;
      OP_HU:   op_error = is_store | byte_off[0];
      default: op_error = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: byte-lane steering between a memory word and the register file.
// Load side extracts and sign/zero-extends a byte or half; store side merges
// the store lane(s) into the old word for read-modify-write.
module lsu_align
  import mips_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  byte_off_i,
  input  logic [2:0]  op_i,
  output logic [31:0] load_data_o,
  output logic [31:0] merged_o
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // Little-endian lanes: offset 0 is bits 7:0, half offset 2 is bits 31:16.
  assign lane_b = word_i[{byte_off_i, 3'b000} +: 8];
  assign lane_h = word_i[{byte_off_i[1], 4'b0000} +: 16];

  // Load extract and extend.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    load_data_o = '0;
    case (op_i)
      OP_B:    load_data_o = {{24{lane_b[7]}}, lane_b};
      OP_BU:   load_data_o = {24'b0, lane_b};
      OP_H:    load_data_o = {{16{lane_h[15]}}, lane_h};
      OP_HU:   load_data_o = {16'b0, lane_h};
      OP_W:    load_data_o = word_i;
      default: load_data_o = '0;
    endcase
  end

  // Store merge: overwrite only the addressed lane(s) of the old word.
  always_comb begin
    merged_o = word_i;
    case (op_i)
      OP_B:    merged_o[{byte_off_i, 3'b000} +: 8]     = wdata_i[7:0];
      OP_H:    merged_o[{byte_off_i[1], 4'b0000} +: 16] = wdata_i[15:0];
      default: merged_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: MEM-stage front end for a byte-enable-less data_memory.
// Latches one request, drives word-indexed reads/writes, performs sub-word
// stores by read-modify-write and returns formatted load data.
module load_store_unit
  import mips_pkg::*;
#(
  parameter int WORD_IDX_W = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [3:0]            req_op,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  output logic                  rsp_err,
  output logic [31:0]           rsp_rdata,
  output logic [WORD_IDX_W-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  mem_write,
  output logic                  mem_read,
  input  logic [31:0]           mem_rdata
);

  localparam int ADDR_W = WORD_IDX_W + 2;

  lsu_state_e        state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       merged_q, merged_d;
  logic              accept;
  logic [31:0]       load_data;
  logic [31:0]       merge_word;

  // Address bits above the word index are deliberately dropped: the address wraps.
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:ADDR_W];

  lsu_align u_align (
    .word_i      (mem_rdata),
    .wdata_i     (wdata_q),
    .byte_off_i  (addr_q[1:0]),
    .op_i        (op_q),
    .load_data_o (load_data),
    .merged_o    (merge_word)
  );

  // State and latched-request registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: only the small request/merge registers are reset; there is no storage array here to clear.
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      merged_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so all registers update together.
      state_q  <= state_d;
      op_q     <= op_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      merged_q <= merged_d;
    end
  end

  // Next-state, request latching and all outputs decoded from the current state.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    merged_d  = merged_q;
    req_ready = rst_n && (state_q == S_IDLE);
    accept    = req_valid && req_ready;
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    rsp_rdata = '0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_wdata = '0;
    mem_addr  = (state_q == S_IDLE) ? '0 : addr_q[ADDR_W-1:2];

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d    = req_op[2:0];
          addr_d  = req_addr[ADDR_W-1:0];
          wdata_d = req_wdata;
          if (op_error(req_op, req_addr[1:0])) begin
            state_d = S_ERR;
          end else if (!req_op[ST_BIT]) begin
            state_d = S_LD_RD;
          end else if (req_op[2:0] == OP_W) begin
            state_d = S_ST_WR;
          end else begin
            state_d = S_RMW_RD;
          end
        end
      end
      S_LD_RD: begin
        mem_read = 1'b1;
        state_d  = S_LD_DATA;
      end
      S_LD_DATA: begin
        rsp_valid = 1'b1;
        rsp_rdata = load_data;
        state_d   = S_IDLE;
      end
      S_ST_WR: begin
        mem_write = 1'b1;
        mem_wdata = wdata_q;
        rsp_valid = 1'b1;
        state_d   = S_IDLE;
      end
      S_RMW_RD: begin
        mem_read = 1'b1;
        state_d  = S_RMW_MRG;
      end
      S_RMW_MRG: begin
        merged_d = merge_word;
        state_d  = S_RMW_WR;
      end
      S_RMW_WR: begin
        mem_write = 1'b1;
        mem_wdata = merged_q;
        rsp_valid = 1'b1;
        state_d   = S_IDLE;
      end
      S_ERR: begin
        rsp_valid = 1'b1;
        rsp_err   = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a behavioural data_memory, a
// reference model computing responses from byte-address arithmetic, and a
// monitor that checks every response, its cycle, and req_ready each cycle.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_op = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_err;
  logic [31:0] rsp_rdata;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_write;
  logic        mem_read;
  logic [31:0] mem_rdata = '0;

  always #5 clk = ~clk;

  load_store_unit #(.WORD_IDX_W(6)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_err   (rsp_err),
    .rsp_rdata (rsp_rdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_write (mem_write),
    .mem_read  (mem_read),
    .mem_rdata (mem_rdata)
  );

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;

  logic [31:0] mem     [64];
  logic [31:0] ref_mem [64];
  exp_t        sb_q[$];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          n_writes = 0;
  int          n_reads = 0;
  int          exp_writes = 0;
  int          exp_reads = 0;
  int          busy_lo = -1;
  int          busy_hi = -1;
  int          acc_cyc = 0;
  bit          chk_ready = 1'b0;
  logic [31:0] last_rdata = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // data_memory: synchronous write, read data valid the cycle after mem_read.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_write) begin
      mem[mem_addr] <= mem_wdata;
      n_writes      <= n_writes + 1;
    end
    if (mem_read) begin
      mem_rdata <= mem[mem_addr];
      n_reads   <= n_reads + 1;
    end
  end

  // Monitor: pop and compare on every response; check ready and strobe exclusion.
  always @(negedge clk) begin
    exp_t e;
    check("strobe_excl", {31'b0, mem_read & mem_write}, 32'd0);
    if (rsp_valid) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rsp_unexpected: got rsp_valid=1 expected no response (cycle %0d)", cyc);
      end else begin
        e = sb_q.pop_front();
        check("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
        check("rsp_rdata", rsp_rdata, e.rdata);
        check("rsp_cycle", cyc, e.cyc);
        last_rdata = rsp_rdata;
      end
    end
    if (rst_n && chk_ready)
      check("req_ready", {31'b0, req_ready}, {31'b0, !(cyc > busy_lo && cyc <= busy_hi)});
  end

  // Reference model: byte-address arithmetic over a word array.
  task automatic model(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd,
                       output exp_t e, output int lat);
    int          idx;
    int          sh;
    int          size;
    int          f;
    bit          st;
    logic [31:0] w;
    logic [31:0] mask;
    idx  = int'(addr[7:2]);
    sh   = 8 * int'(addr[1:0]);
    f    = int'(op[2:0]);
    st   = op[3];
    size = (f == 0 || f == 4) ? 1 : (f == 1 || f == 5) ? 2 : (f == 3) ? 4 : 0;
    e.rdata = '0;
    e.err   = (size == 0) || (st && f >= 4) || (int'(addr[1:0]) % (size == 0 ? 1 : size) != 0);
    if (e.err) begin
      lat = 1;
    end else if (!st) begin
      lat = 2;
      exp_reads++;
      w = ref_mem[idx] >> sh;
      if (size == 1) begin
        e.rdata = w & 32'hFF;
        if (f == 0 && e.rdata >= 32'h80) e.rdata = e.rdata - 32'h100;
      end else if (size == 2) begin
        e.rdata = w & 32'hFFFF;
        if (f == 1 && e.rdata >= 32'h8000) e.rdata = e.rdata - 32'h10000;
      end else begin
        e.rdata = w;
      end
    end else begin
      exp_writes++;
      if (size == 4) begin
        lat  = 1;
        mask = 32'hFFFF_FFFF;
      end else begin
        lat = 3;
        exp_reads++;
        mask = ((32'd1 << (8 * size)) - 32'd1) << sh;
      end
      ref_mem[idx] = (ref_mem[idx] & ~mask) | ((wd << sh) & mask);
    end
  endtask

  // Present a request, wait (bounded) for acceptance, push its expected response.
  task automatic issue(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd);
    exp_t e;
    int   lat;
    int   n;
    n = 0;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wd;
    req_valid = 1'b1;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: got req_ready=0 expected 1 within 50 cycles");
      req_valid = 1'b0;
      return;
    end
    model(op, addr, wd, e, lat);
    e.cyc   = cyc + lat;
    acc_cyc = cyc;
    busy_lo = cyc;
    busy_hi = cyc + lat;
    sb_q.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
    req_op    = 4'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;
  endtask

  // Wait (bounded) for all outstanding responses, plus one cycle for the final write.
  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (sb_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending responses expected 0", sb_q.size());
      sb_q.delete();
    end
    @(negedge clk);
    #1;
  endtask

  initial begin
    int          sw_acc;
    logic [3:0]  op;
    logic [31:0] addr;
    for (int i = 0; i < 64; i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[5]     = 32'h8899AABB;
    ref_mem[5] = 32'h8899AABB;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_req_ready", {31'b0, req_ready}, 32'd0);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_rsp_err",   {31'b0, rsp_err},   32'd0);
    check("rst_rsp_rdata", rsp_rdata,          32'd0);
    check("rst_strobes",   {30'b0, mem_read, mem_write}, 32'd0);
    check("rst_mem_addr",  {26'b0, mem_addr},  32'd0);
    rst_n     = 1'b1;
    chk_ready = 1'b1;
    @(negedge clk);

    // Sub-word loads from word 5.
    issue(4'b0000, 32'h16, 32'h0); drain(); check("lb_0x16",  last_rdata, 32'hFFFFFF99);
    issue(4'b0100, 32'h16, 32'h0); drain(); check("lbu_0x16", last_rdata, 32'h00000099);
    issue(4'b0001, 32'h16, 32'h0); drain(); check("lh_0x16",  last_rdata, 32'hFFFF8899);
    issue(4'b0101, 32'h16, 32'h0); drain(); check("lhu_0x16", last_rdata, 32'h00008899);

    // Sub-word stores by read-modify-write.
    issue(4'b1000, 32'h15, 32'h1234565A); drain(); check("sb_word5", mem[5], 32'h88995ABB);
    issue(4'b1001, 32'h14, 32'h0000CAFE); drain(); check("sh_word5", mem[5], 32'h8899CAFE);

    // Error responses.
    issue(4'b0011, 32'h12, 32'h0);
    issue(4'b1001, 32'h11, 32'h0);
    issue(4'b0110, 32'h20, 32'h0);
    drain();

    // SW then back-to-back LW.
    issue(4'b1011, 32'h20, 32'hDEADBEEF);
    sw_acc = acc_cyc;
    issue(4'b0011, 32'h20, 32'h0);
    check("sw_lw_gap", acc_cyc - sw_acc, 32'd2);
    drain();
    check("lw_after_sw", last_rdata, 32'hDEADBEEF);

    // Reset during RMW_WR: write dropped, no response.
    req_op    = 4'b1000;
    req_addr  = 32'h15;
    req_wdata = 32'h00000077;
    req_valid = 1'b1;
    check("rmw_abort_ready", {31'b0, req_ready}, 32'd1);
    busy_lo = cyc;
    busy_hi = cyc + 3;
    exp_reads++;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1;
    check("rmw_wr_reached", {31'b0, mem_write}, 32'd1);
    chk_ready = 1'b0;
    rst_n     = 1'b0;
    #1;
    check("abort_mem_write", {31'b0, mem_write}, 32'd0);
    check("abort_mem_read",  {31'b0, mem_read},  32'd0);
    check("abort_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("abort_req_ready", {31'b0, req_ready}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_ready", {31'b0, req_ready}, 32'd1);
    check("word5_unchanged", mem[5], 32'h8899CAFE);
    busy_lo   = -1;
    busy_hi   = -1;
    chk_ready = 1'b1;
    issue(4'b0011, 32'h14, 32'h0); drain(); check("lw_word5_after_abort", last_rdata, 32'h8899CAFE);

    // Address wrap.
    issue(4'b1011, 32'h100, 32'h13579BDF);
    issue(4'b0011, 32'h000, 32'h0);
    drain();
    check("wrap_lw", last_rdata, 32'h13579BDF);
    check("wrap_mem0", mem[0], 32'h13579BDF);

    // Randomized traffic, mostly aligned.
    for (int i = 0; i < 300; i++) begin
      op   = 4'($urandom_range(0, 15));
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (op[1:0] == 2'b11) addr[1:0] = 2'b00;
        else if (op[0]) addr[0] = 1'b0;
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue(op, addr, $urandom);
    end
    drain();

    check("write_count", n_writes, exp_writes);
    check("read_count",  n_reads,  exp_reads);
    for (int i = 0; i < 64; i++) check($sformatf("mem_final[%0d]", i), mem[i], ref_mem[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation time limit expected test completion");
    $fatal(1, "watchdog expired");
  end

endmodule
